// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory access arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times one memory access; flags the final cycle before read data is valid.
module mem_latency_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] loadVal,
  output logic             expiring
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Count reaches zero on the DONE cycle, so a count of one means the next cycle is DONE.
  assign expiring = (count == LAT_W'(1));

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing single-ported main memory between instruction fetch and data port.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_load,
  output logic              mdr_load,
  output logic              busy,
  output state_e            dbgState
);

  // Handshake: req is a level held until the matching one-cycle done pulse; gnt pulses with mem_en.

  state_e state;
  logic   lastGrant;
  logic   pick;
  logic   anyReq;
  logic   expiring;
  logic   unusedRdata;

  assign anyReq      = if_req | dm_req;
  assign unusedRdata = ^mem_rdata;
  assign dbgState    = state;

  always_comb begin
    pick = PORT_DM;
    if (if_req && dm_req) pick = (lastGrant == PORT_IF) ? PORT_DM : PORT_IF;
    else if (if_req)      pick = PORT_IF;
  end

  mem_latency_counter u_latency (
    .clk      (clk),
    .reset    (reset),
    .load     (state == IDLE && anyReq),
    .dec      (state == ACCESS || state == WAIT),
    .loadVal  (LAT_W'(MEM_LATENCY)),
    .expiring (expiring)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= PORT_DM;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      dm_gnt    <= 1'b0;
      dm_done   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir_load   <= 1'b0;
      mdr_load  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if_gnt   <= 1'b0;
      if_done  <= 1'b0;
      dm_gnt   <= 1'b0;
      dm_done  <= 1'b0;
      mem_en   <= 1'b0;
      ir_load  <= 1'b0;
      mdr_load <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            lastGrant <= pick;
            mem_addr  <= (pick == PORT_IF) ? if_addr : dm_addr;
            mem_we    <= (pick == PORT_DM) && dm_we;
            // Fetches are reads, so the previous store data is simply held.
            if (pick == PORT_DM) mem_wdata <= dm_wdata;
            mem_en <= 1'b1;
            if_gnt <= (pick == PORT_IF);
            dm_gnt <= (pick == PORT_DM);
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS, WAIT: begin
          if (expiring) begin
            if_done  <= (lastGrant == PORT_IF);
            dm_done  <= (lastGrant == PORT_DM);
            ir_load  <= (lastGrant == PORT_IF);
            mdr_load <= (lastGrant == PORT_DM) && !mem_we;
            state    <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter at latency 2 (dut) and latency 1 (dut1).
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, ir_load, mdr_load, busy;
  logic [31:0] mem_addr, mem_wdata;
  state_e      dbgState;

  logic        ifReq1, dmReq1, dmWe1;
  logic [31:0] ifAddr1, dmAddr1, dmWdata1;
  logic        ifGnt1, ifDone1, dmGnt1, dmDone1, memEn1, memWe1, irLoad1, mdrLoad1, busy1;
  logic [31:0] memAddr1, memWdata1;
  state_e      dbgState1;

  int tests = 0;
  int fails = 0;

  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ir_load(ir_load), .mdr_load(mdr_load), .busy(busy),
    .dbgState(dbgState)
  );

  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(ifReq1), .if_addr(ifAddr1), .if_gnt(ifGnt1), .if_done(ifDone1),
    .dm_req(dmReq1), .dm_we(dmWe1), .dm_addr(dmAddr1), .dm_wdata(dmWdata1),
    .dm_gnt(dmGnt1), .dm_done(dmDone1),
    .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_rdata(mem_rdata), .ir_load(irLoad1), .mdr_load(mdrLoad1), .busy(busy1),
    .dbgState(dbgState1)
  );

  // Pulse vector order: {if_gnt, if_done, dm_gnt, dm_done, mem_en, ir_load, mdr_load, busy}
  function automatic logic [7:0] pulses();
    return {if_gnt, if_done, dm_gnt, dm_done, mem_en, ir_load, mdr_load, busy};
  endfunction

  function automatic logic [7:0] pulses1();
    return {ifGnt1, ifDone1, dmGnt1, dmDone1, memEn1, irLoad1, mdrLoad1, busy1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    ifReq1 = 1'b0; dmReq1 = 1'b0; dmWe1 = 1'b0;
    ifAddr1 = '0; dmAddr1 = '0; dmWdata1 = '0;
  endtask

  // Returns in cycle 0: reset was sampled low at the edge starting it, high from here on.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h1234; dm_req = 1'b1; dm_we = 1'b1;
    dm_addr = 32'h5678; dm_wdata = 32'hCAFEF00D;
    step();
    step();
    @(negedge clk);
    tests++;
    if (pulses() !== 8'h00 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b we=%b, want 00000000 we=0", pulses(), mem_we);
    end
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || dbgState !== IDLE) begin
      fails++;
      $display("FAIL reset_regs: got addr=%h wdata=%h state=%0d, want 0 0 IDLE",
               mem_addr, mem_wdata, dbgState);
    end
  endtask

  task automatic test_fetch();
    logic [7:0] exp;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      case (c)
        1:       exp = 8'h89;
        2:       exp = 8'h01;
        3:       exp = 8'h45;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses() !== exp) begin
        fails++;
        $display("FAIL fetch_c%0d: got %b want %b", c, pulses(), exp);
      end
      if (c == 1) begin
        tests++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL fetch_addr: got addr=%h we=%b want 00000100 0", mem_addr, mem_we);
        end
      end
      step();
      if (c == 3) if_req = 1'b0;
    end
  endtask

  task automatic test_arbitrate();
    logic [7:0] exp;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      case (c)
        1:       exp = 8'h89;
        2, 6:    exp = 8'h01;
        3:       exp = 8'h45;
        5:       exp = 8'h29;
        7:       exp = 8'h13;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses() !== exp) begin
        fails++;
        $display("FAIL arb_c%0d: got %b want %b", c, pulses(), exp);
      end
      if (c == 5) begin
        tests++;
        if (mem_addr !== 32'h200 || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL arb_dm_addr: got addr=%h we=%b want 00000200 0", mem_addr, mem_we);
        end
      end
      step();
      if (c == 3) if_req = 1'b0;
      if (c == 7) dm_req = 1'b0;
    end
  endtask

  task automatic test_store();
    logic [7:0] exp;
    apply_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      case (c)
        1:       exp = 8'h29;
        2:       exp = 8'h01;
        3:       exp = 8'h11;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses() !== exp) begin
        fails++;
        $display("FAIL store_c%0d: got %b want %b", c, pulses(), exp);
      end
      if (c == 1 || c == 3) begin
        tests++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h40) begin
          fails++;
          $display("FAIL store_latch_c%0d: got we=%b wdata=%h addr=%h want 1 deadbeef 00000040",
                   c, mem_we, mem_wdata, mem_addr);
        end
      end
      step();
      if (c == 1) begin
        dm_addr = 32'h44; dm_wdata = 32'h0;
      end
      if (c == 3) dm_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp;
    logic [31:0] expAddr;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      case (c % 8)
        1:       exp = 8'h89;
        2, 6:    exp = 8'h01;
        3:       exp = 8'h45;
        5:       exp = 8'h29;
        7:       exp = 8'h13;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses() !== exp) begin
        fails++;
        $display("FAIL b2b_c%0d: got %b want %b", c, pulses(), exp);
      end
      if (c % 4 == 1) begin
        expAddr = (c % 8 == 1) ? 32'h300 : 32'h400;
        tests++;
        if (mem_addr !== expAddr) begin
          fails++;
          $display("FAIL b2b_addr_c%0d: got %h want %h", c, mem_addr, expAddr);
        end
      end
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] exp;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      case (c)
        1, 4:    exp = 8'h89;
        2, 5:    exp = 8'h01;
        6:       exp = 8'h45;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses() !== exp) begin
        fails++;
        $display("FAIL rstmid_c%0d: got %b want %b", c, pulses(), exp);
      end
      if (c == 3) begin
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0 || dbgState !== IDLE) begin
          fails++;
          $display("FAIL rstmid_regs: got addr=%h wdata=%h we=%b state=%0d want 0 0 0 IDLE",
                   mem_addr, mem_wdata, mem_we, dbgState);
        end
      end
      if (c == 4) begin
        tests++;
        if (mem_addr !== 32'h100) begin
          fails++;
          $display("FAIL rstmid_regrant_addr: got %h want 00000100", mem_addr);
        end
      end
      step();
      if (c == 1) reset = 1'b0;
      if (c == 2) reset = 1'b1;
      if (c == 6) if_req = 1'b0;
    end
  endtask

  task automatic test_latency_one();
    logic [7:0] exp;
    logic       sawWait;
    apply_reset();
    sawWait = 1'b0;
    dmReq1 = 1'b1; dmWe1 = 1'b0; dmAddr1 = 32'h80;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      case (c)
        1:       exp = 8'h29;
        2:       exp = 8'h13;
        default: exp = 8'h00;
      endcase
      tests++;
      if (pulses1() !== exp) begin
        fails++;
        $display("FAIL lat1_c%0d: got %b want %b", c, pulses1(), exp);
      end
      if (dbgState1 == WAIT) sawWait = 1'b1;
      step();
      if (c == 2) dmReq1 = 1'b0;
    end
    tests++;
    if (sawWait !== 1'b0) begin
      fails++;
      $display("FAIL lat1_wait_state: got entered=%b want 0", sawWait);
    end
  endtask

  initial begin
    mem_rdata = 32'hA5A5A5A5;
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_fetch();
    test_arbitrate();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
    test_latency_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
